// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared widths, setup state type and small helpers for triangle setup
package gpu_pkg;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int Z_W    = 16;
  localparam int INV_W  = 32;
  localparam int A_W    = 9;
  localparam int B_W    = 10;
  localparam int P_W    = 17;
  localparam int C_W    = 18;
  localparam int AREA_W = 20;
  localparam int DROP_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDGE,
    ST_CMUL,
    ST_CSUM,
    ST_AREA,
    ST_ORIENT,
    ST_ISSUE,
    ST_WAIT
  } setup_state_t;

  function automatic logic [X_W-1:0] min3(input logic [X_W-1:0] a, input logic [X_W-1:0] b,
                                          input logic [X_W-1:0] c);
    logic [X_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [X_W-1:0] max3(input logic [X_W-1:0] a, input logic [X_W-1:0] b,
                                          input logic [X_W-1:0] c);
    logic [X_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [X_W-1:0] clamp(input logic [X_W-1:0] v, input logic [X_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/edge_setup.sv
// rtl/edge_setup.sv - one edge equation (A, B, C) from vertex a to vertex b, staged over
// EDGE/CMUL/CSUM with an in-place negate used to normalise winding.
module edge_setup
  import gpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_W-1:0]        xa,
  input  logic [Y_W-1:0]        ya,
  input  logic [X_W-1:0]        xb,
  input  logic [Y_W-1:0]        yb,
  input  logic                  edge_en,
  input  logic                  cmul_en,
  input  logic                  csum_en,
  input  logic                  neg_en,
  output logic signed [A_W-1:0] a,
  output logic signed [B_W-1:0] b,
  output logic signed [C_W-1:0] c
);

  logic signed [A_W-1:0] a_q, a_d;
  logic signed [B_W-1:0] b_q, b_d;
  logic signed [C_W-1:0] c_q, c_d;
  logic [P_W-1:0]        p1_q, p1_d;
  logic [P_W-1:0]        p2_q, p2_d;

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    c_d  = c_q;
    p1_d = p1_q;
    p2_d = p2_q;
    if (edge_en) begin
      a_d = $signed({1'b0, ya}) - $signed({1'b0, yb});
      b_d = $signed({1'b0, xb}) - $signed({1'b0, xa});
    end
    if (cmul_en) begin
      p1_d = P_W'(xa) * P_W'(yb);
      p2_d = P_W'(xb) * P_W'(ya);
    end
    if (csum_en) begin
      c_d = $signed({1'b0, p1_q}) - $signed({1'b0, p2_q});
    end
    if (neg_en) begin
      a_d = -a_q;
      b_d = -b_q;
      c_d = -c_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
    end
  end

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;

endmodule

// File: rtl/triangle_setup.sv
// rtl/triangle_setup.sv - triangle setup ahead of the rasterizer: edges, bbox, winding, start/done.
// Define BACKFACE_CULL_EN to drop negative-area triangles instead of rasterizing them two-sided.
module triangle_setup
  import gpu_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tri_valid,
  output logic                  tri_ready,
  input  logic [X_W-1:0]        vx1,
  input  logic [X_W-1:0]        vx2,
  input  logic [X_W-1:0]        vx3,
  input  logic [Y_W-1:0]        vy1,
  input  logic [Y_W-1:0]        vy2,
  input  logic [Y_W-1:0]        vy3,
  input  logic [Z_W-1:0]        vz1,
  input  logic [Z_W-1:0]        vz2,
  input  logic [Z_W-1:0]        vz3,
  input  logic [INV_W-1:0]      inv_area_in,
  output logic signed [A_W-1:0] a1,
  output logic signed [A_W-1:0] a2,
  output logic signed [A_W-1:0] a3,
  output logic signed [B_W-1:0] b1,
  output logic signed [B_W-1:0] b2,
  output logic signed [B_W-1:0] b3,
  output logic signed [C_W-1:0] c1,
  output logic signed [C_W-1:0] c2,
  output logic signed [C_W-1:0] c3,
  output logic [X_W-1:0]        bbxi,
  output logic [X_W-1:0]        bbxf,
  output logic [Y_W-1:0]        bbyi,
  output logic [Y_W-1:0]        bbyf,
  output logic [Z_W-1:0]        z1,
  output logic [Z_W-1:0]        z2,
  output logic [Z_W-1:0]        z3,
  output logic [INV_W-1:0]      inv_area,
  output logic                  rasterizer_start,
  input  logic                  rasterizer_done,
  output logic [DROP_W-1:0]     drop_count
);

  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W - 1);
  localparam logic [X_W-1:0] Y_LIM = X_W'(SCREEN_H - 1);

  setup_state_t state_q, state_d;

  // Vertex latch captured on accept; separate from the output copies so that
  // outputs only move during the setup states.
  logic [X_W-1:0]           vx_q [3];
  logic [X_W-1:0]           vx_d [3];
  logic [Y_W-1:0]           vy_q [3];
  logic [Y_W-1:0]           vy_d [3];
  logic [Z_W-1:0]           vz_q [3];
  logic [Z_W-1:0]           vz_d [3];
  logic [INV_W-1:0]         inv_in_q, inv_in_d;

  logic [Z_W-1:0]           zo_q [3];
  logic [Z_W-1:0]           zo_d [3];
  logic [INV_W-1:0]         inv_area_q, inv_area_d;
  logic [X_W-1:0]           bbxi_q, bbxi_d, bbxf_q, bbxf_d;
  logic [Y_W-1:0]           bbyi_q, bbyi_d, bbyf_q, bbyf_d;
  logic signed [AREA_W-1:0] area_q, area_d;
  logic                     start_q, start_d;
  logic [DROP_W-1:0]        drop_q, drop_d;

  logic edge_en, cmul_en, csum_en, neg_en;
  logic area_neg, area_zero;

  assign area_neg  = area_q[AREA_W-1];
  assign area_zero = (area_q == '0);
  assign edge_en   = (state_q == ST_EDGE);
  assign cmul_en   = (state_q == ST_CMUL);
  assign csum_en   = (state_q == ST_CSUM);
`ifdef BACKFACE_CULL_EN
  assign neg_en    = 1'b0;
`else
  assign neg_en    = (state_q == ST_ORIENT) && area_neg;
`endif

  edge_setup u_edge1 (
    .clk(clk), .rst(rst),
    .xa(vx_q[0]), .ya(vy_q[0]), .xb(vx_q[1]), .yb(vy_q[1]),
    .edge_en(edge_en), .cmul_en(cmul_en), .csum_en(csum_en), .neg_en(neg_en),
    .a(a1), .b(b1), .c(c1)
  );

  edge_setup u_edge2 (
    .clk(clk), .rst(rst),
    .xa(vx_q[1]), .ya(vy_q[1]), .xb(vx_q[2]), .yb(vy_q[2]),
    .edge_en(edge_en), .cmul_en(cmul_en), .csum_en(csum_en), .neg_en(neg_en),
    .a(a2), .b(b2), .c(c2)
  );

  edge_setup u_edge3 (
    .clk(clk), .rst(rst),
    .xa(vx_q[2]), .ya(vy_q[2]), .xb(vx_q[0]), .yb(vy_q[0]),
    .edge_en(edge_en), .cmul_en(cmul_en), .csum_en(csum_en), .neg_en(neg_en),
    .a(a3), .b(b3), .c(c3)
  );

  always_comb begin
    state_d    = state_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    vz_d       = vz_q;
    inv_in_d   = inv_in_q;
    zo_d       = zo_q;
    inv_area_d = inv_area_q;
    bbxi_d     = bbxi_q;
    bbxf_d     = bbxf_q;
    bbyi_d     = bbyi_q;
    bbyf_d     = bbyf_q;
    area_d     = area_q;
    start_d    = 1'b0;
    drop_d     = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (tri_valid) begin
          vx_d     = '{vx1, vx2, vx3};
          vy_d     = '{vy1, vy2, vy3};
          vz_d     = '{vz1, vz2, vz3};
          inv_in_d = inv_area_in;
          state_d  = ST_EDGE;
        end
      end
      ST_EDGE: begin
        bbxi_d     = clamp(min3(vx_q[0], vx_q[1], vx_q[2]), X_LIM);
        bbxf_d     = clamp(max3(vx_q[0], vx_q[1], vx_q[2]), X_LIM);
        bbyi_d     = Y_W'(clamp(min3({1'b0, vy_q[0]}, {1'b0, vy_q[1]}, {1'b0, vy_q[2]}), Y_LIM));
        bbyf_d     = Y_W'(clamp(max3({1'b0, vy_q[0]}, {1'b0, vy_q[1]}, {1'b0, vy_q[2]}), Y_LIM));
        zo_d       = vz_q;
        inv_area_d = inv_in_q;
        state_d    = ST_CMUL;
      end
      ST_CMUL: state_d = ST_CSUM;
      ST_CSUM: state_d = ST_AREA;
      ST_AREA: begin
        area_d  = {{(AREA_W-C_W){c1[C_W-1]}}, c1} + {{(AREA_W-C_W){c2[C_W-1]}}, c2}
                + {{(AREA_W-C_W){c3[C_W-1]}}, c3};
        state_d = ST_ORIENT;
      end
      ST_ORIENT: begin
`ifdef BACKFACE_CULL_EN
        if (area_zero || area_neg) begin
`else
        if (area_zero) begin
`endif
          drop_d  = sat_inc(drop_q);
          state_d = ST_IDLE;
        end else begin
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rasterizer_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
        vz_q[i] <= '0;
        zo_q[i] <= '0;
      end
      inv_in_q   <= '0;
      inv_area_q <= '0;
      bbxi_q     <= '0;
      bbxf_q     <= '0;
      bbyi_q     <= '0;
      bbyf_q     <= '0;
      area_q     <= '0;
      start_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      vz_q       <= vz_d;
      zo_q       <= zo_d;
      inv_in_q   <= inv_in_d;
      inv_area_q <= inv_area_d;
      bbxi_q     <= bbxi_d;
      bbxf_q     <= bbxf_d;
      bbyi_q     <= bbyi_d;
      bbyf_q     <= bbyf_d;
      area_q     <= area_d;
      start_q    <= start_d;
      drop_q     <= drop_d;
    end
  end

  assign tri_ready        = (state_q == ST_IDLE);
  assign rasterizer_start = start_q;
  assign drop_count       = drop_q;
  assign bbxi             = bbxi_q;
  assign bbxf             = bbxf_q;
  assign bbyi             = bbyi_q;
  assign bbyf             = bbyf_q;
  assign z1               = zo_q[0];
  assign z2               = zo_q[1];
  assign z3               = zo_q[2];
  assign inv_area         = inv_area_q;

endmodule

// File: tb/tb_triangle_setup.sv
// tb/tb_triangle_setup.sv - self-checking bench for triangle_setup against a plain-arithmetic model
module tb_triangle_setup;

  logic               clk = 1'b0;
  logic               rst;
  logic               tri_valid;
  logic               tri_ready;
  logic [8:0]         vx1, vx2, vx3;
  logic [7:0]         vy1, vy2, vy3;
  logic [15:0]        vz1, vz2, vz3;
  logic [31:0]        inv_area_in;
  logic signed [8:0]  a1, a2, a3;
  logic signed [9:0]  b1, b2, b3;
  logic signed [17:0] c1, c2, c3;
  logic [8:0]         bbxi, bbxf;
  logic [7:0]         bbyi, bbyf;
  logic [15:0]        z1, z2, z3;
  logic [31:0]        inv_area;
  logic               rasterizer_start;
  logic               rasterizer_done;
  logic [15:0]        drop_count;

  triangle_setup dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .vx1(vx1), .vx2(vx2), .vx3(vx3), .vy1(vy1), .vy2(vy2), .vy3(vy3),
    .vz1(vz1), .vz2(vz2), .vz3(vz3), .inv_area_in(inv_area_in),
    .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3), .c1(c1), .c2(c2), .c3(c3),
    .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
    .z1(z1), .z2(z2), .z3(z3), .inv_area(inv_area),
    .rasterizer_start(rasterizer_start), .rasterizer_done(rasterizer_done),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int tx [3];
  int ty [3];
  int ex_a [3];
  int ex_b [3];
  int ex_c [3];
  int ex_bx0, ex_bx1, ex_by0, ex_by1;
  bit ex_drop;
  int drop_exp = 0;
  logic [15:0] ex_z [3];
  logic [31:0] ex_inv;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edge k spans vertex k -> k+1; positive area keeps coefficients, negative flips them.
  function automatic void model();
    int area = 0;
    for (int k = 0; k < 3; k++) begin
      int n = (k + 1) % 3;
      ex_a[k] = ty[k] - ty[n];
      ex_b[k] = tx[n] - tx[k];
      ex_c[k] = tx[k] * ty[n] - tx[n] * ty[k];
      area += ex_c[k];
    end
    ex_drop = (area == 0);
`ifdef BACKFACE_CULL_EN
    if (area < 0) ex_drop = 1'b1;
`endif
    if (area < 0 && !ex_drop)
      for (int k = 0; k < 3; k++) begin
        ex_a[k] = -ex_a[k];
        ex_b[k] = -ex_b[k];
        ex_c[k] = -ex_c[k];
      end
    ex_bx0 = tx[0]; ex_bx1 = tx[0]; ex_by0 = ty[0]; ex_by1 = ty[0];
    for (int k = 1; k < 3; k++) begin
      if (tx[k] < ex_bx0) ex_bx0 = tx[k];
      if (tx[k] > ex_bx1) ex_bx1 = tx[k];
      if (ty[k] < ex_by0) ex_by0 = ty[k];
      if (ty[k] > ex_by1) ex_by1 = ty[k];
    end
    if (ex_bx0 > 319) ex_bx0 = 319;
    if (ex_bx1 > 319) ex_bx1 = 319;
    if (ex_by0 > 239) ex_by0 = 239;
    if (ex_by1 > 239) ex_by1 = 239;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, "_a1"}, a1, ex_a[0]);
    check_eq({tag, "_a2"}, a2, ex_a[1]);
    check_eq({tag, "_a3"}, a3, ex_a[2]);
    check_eq({tag, "_b1"}, b1, ex_b[0]);
    check_eq({tag, "_b2"}, b2, ex_b[1]);
    check_eq({tag, "_b3"}, b3, ex_b[2]);
    check_eq({tag, "_c1"}, c1, ex_c[0]);
    check_eq({tag, "_c2"}, c2, ex_c[1]);
    check_eq({tag, "_c3"}, c3, ex_c[2]);
    check_eq({tag, "_bbxi"}, bbxi, ex_bx0);
    check_eq({tag, "_bbxf"}, bbxf, ex_bx1);
    check_eq({tag, "_bbyi"}, bbyi, ex_by0);
    check_eq({tag, "_bbyf"}, bbyf, ex_by1);
    check_eq({tag, "_z"}, {z1, z2, z3}, {ex_z[0], ex_z[1], ex_z[2]});
    check_eq({tag, "_inv"}, inv_area, ex_inv);
  endtask

  task automatic check_zero(input string tag);
    int nz;
    nz = (a1 != 0) + (a2 != 0) + (a3 != 0) + (b1 != 0) + (b2 != 0) + (b3 != 0)
       + (c1 != 0) + (c2 != 0) + (c3 != 0) + (bbxi != 0) + (bbxf != 0) + (bbyi != 0)
       + (bbyf != 0) + (z1 != 0) + (z2 != 0) + (z3 != 0) + (inv_area != 0);
    check_eq({tag, "_nonzero_outputs"}, nz, 0);
    check_eq({tag, "_start"}, rasterizer_start, 0);
    check_eq({tag, "_drop"}, drop_count, 0);
  endtask

  // Called just after a negedge with the DUT idle. mode: 0 plain, 1 hold a second
  // triangle on the bus during WAIT, 2 assert reset while in WAIT.
  task automatic do_tri(input int x1, input int y1, input int x2, input int y2,
                        input int x3, input int y3, input int mode);
    int   nstart = 0;
    int   scyc = 0;
    logic r5 = 1'b0;
    logic r6 = 1'b0;
    tx = '{x1, x2, x3};
    ty = '{y1, y2, y3};
    model();
    for (int k = 0; k < 3; k++) ex_z[k] = 16'($urandom);
    ex_inv = $urandom;
    vx1 = 9'(x1); vx2 = 9'(x2); vx3 = 9'(x3);
    vy1 = 8'(y1); vy2 = 8'(y2); vy3 = 8'(y3);
    vz1 = ex_z[0]; vz2 = ex_z[1]; vz3 = ex_z[2];
    inv_area_in = ex_inv;
    tri_valid = 1'b1;
    check_eq("ready_idle", tri_ready, 1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) begin
        tri_valid = 1'b0;
        vx1 = 9'($urandom); vy2 = 8'($urandom); vz3 = 16'($urandom); inv_area_in = $urandom;
      end
      rasterizer_done = (i == 2);
      if (rasterizer_start) begin
        nstart++;
        scyc = i;
      end
      if (i == 5) r5 = tri_ready;
      if (i == 6) r6 = tri_ready;
    end
    if (ex_drop) begin
      if (drop_exp < 65535) drop_exp++;
      check_eq("drop_nstart", nstart, 0);
      check_eq("drop_ready_c5", r5, 0);
      check_eq("drop_ready_c6", r6, 1);
    end else begin
      check_eq("start_cycle", scyc, 6);
      check_eq("start_count", nstart, 1);
      check_outputs("issue");
      check_eq("wait_ready", tri_ready, 0);
      if (mode == 2) begin
        #2 rst = 1'b0;
        #1 check_zero("rst_wait");
        drop_exp = 0;
        check_eq("rst_ready", tri_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        rasterizer_done = 1'b1;
        @(negedge clk);
        rasterizer_done = 1'b0;
        check_eq("post_rst_ready", tri_ready, 1);
        check_eq("post_rst_start", rasterizer_start, 0);
        check_zero("post_rst");
      end else begin
        if (mode == 1) begin
          tri_valid = 1'b1;
          vx1 = 9'($urandom); vy1 = 8'($urandom); vx3 = 9'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("wait_hold_ready", tri_ready, 0);
          check_eq("wait_hold_start", rasterizer_start, 0);
        end
        check_outputs("stable");
        rasterizer_done = 1'b1;
        @(negedge clk);
        rasterizer_done = 1'b0;
        check_eq("done_ready", tri_ready, 1);
      end
    end
    check_eq("drop_count", drop_count, drop_exp);
  endtask

  initial begin
    int rx [3];
    int ry [3];
    rst = 1'b0;
    tri_valid = 1'b0;
    rasterizer_done = 1'b0;
    vx1 = '0; vx2 = '0; vx3 = '0; vy1 = '0; vy2 = '0; vy3 = '0;
    vz1 = '0; vz2 = '0; vz3 = '0; inv_area_in = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_eq("reset_ready", tri_ready, 1);

    do_tri(10, 10, 50, 10, 10, 40, 0);
    do_tri(10, 10, 10, 40, 50, 10, 0);
    do_tri(0, 0, 10, 10, 20, 20, 0);
    do_tri(400, 250, 10, 10, 50, 30, 0);
    do_tri(10, 10, 50, 10, 10, 40, 1);
    do_tri(20, 30, 200, 35, 60, 150, 0);
    do_tri(30, 20, 100, 20, 30, 90, 2);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 3; k++) begin
        rx[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 330));
        ry[k] = int'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 5) == 0) begin
        rx[2] = rx[0];
        ry[2] = ry[0];
      end
      do_tri(rx[0], ry[0], rx[1], ry[1], rx[2], ry[2], ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
